// File: rtl/datapath_mc.sv
// Multi-cycle datapath: 16-entry register file, PC, and a RUN/MEM controller
// that holds a single memory request open until the memory acknowledges it.
module datapath_mc #(
  parameter int               WIDTH    = 16,
  parameter int               PC_STEP  = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      instruction,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             reg_write,
  input  logic             reg_set,
  input  logic             reg_set_upper,
  input  logic             PC_select,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] write_data,
  input  logic [WIDTH-1:0] read_data,
  output logic [WIDTH-1:0] PC
);

  typedef enum logic {RUN, MEM} state_t;

  state_t           r_state, w_stateNext;
  logic [WIDTH-1:0] r_regs [16];
  logic [WIDTH-1:0] r_pc, r_memAddr, r_memData;
  logic [3:0]       r_memZ;
  logic             r_memWe;

  logic [3:0]       w_x, w_y, w_z;
  logic [7:0]       w_imm;
  logic [WIDTH-1:0] w_regX, w_regY, w_setVal, w_wrData, w_pcNext;
  logic [3:0]       w_wrAddr;
  logic             w_wrEn, w_pcEn, w_accept, w_isMem, w_unused;

  assign w_x      = instruction[11:8];
  assign w_y      = instruction[7:4];
  assign w_z      = instruction[3:0];
  assign w_imm    = instruction[11:4];
  assign w_unused = ^instruction[15:12];

  // r0 is never written, so a plain read always returns 0 for it
  assign w_regX   = r_regs[w_x];
  assign w_regY   = r_regs[w_y];
  assign w_accept = instr_valid && (r_state == RUN);
  assign w_isMem  = mem_read || mem_write;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RUN: if (w_accept && w_isMem) w_stateNext = MEM;
      MEM: if (mem_ack)             w_stateNext = RUN;
      default:                      w_stateNext = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_wrEn          = 1'b0;
    w_wrAddr        = w_z;
    w_wrData        = alu_result;
    w_pcEn          = 1'b0;
    w_pcNext        = r_pc + WIDTH'(PC_STEP);
    w_setVal        = r_regs[w_z];
    w_setVal[15:8]  = w_imm;
    if (r_state == RUN) begin
      if (w_accept && !w_isMem) begin
        w_pcEn = 1'b1;
        if (PC_select) w_pcNext = w_regX;
        w_wrEn = reg_set || reg_write;
        if (reg_set)
          w_wrData = reg_set_upper ? w_setVal : {{(WIDTH-8){1'b0}}, w_imm};
      end
    end else if (mem_ack) begin
      w_pcEn   = 1'b1;
      w_wrEn   = !r_memWe;
      w_wrAddr = r_memZ;
      w_wrData = read_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_memAddr <= '0;
      r_memData <= '0;
      r_memZ    <= '0;
      r_memWe   <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      if (w_pcEn) r_pc <= w_pcNext;
      if (w_wrEn && (w_wrAddr != 4'd0)) r_regs[w_wrAddr] <= w_wrData;
      // A simultaneous read+write request is treated as a store
      if (w_accept && w_isMem) begin
        r_memAddr <= w_regX;
        r_memData <= w_regY;
        r_memZ    <= w_z;
        r_memWe   <= mem_write;
      end
    end
  end

  assign instr_ready = (r_state == RUN);
  assign mem_req     = (r_state == MEM);
  assign mem_we      = (r_state == MEM) && r_memWe;
  assign address     = (r_state == MEM) ? r_memAddr : '0;
  assign write_data  = (r_state == MEM) ? r_memData : '0;
  assign alu_a       = w_regX;
  assign alu_b       = w_regY;
  assign PC          = r_pc;

endmodule

// File: tb/tb_datapath_mc.sv
// Scoreboard-driven bench for datapath_mc: expected values are queued when
// stimulus is applied and compared against DUT observations per scenario.
module tb_datapath_mc;

  logic        clock = 1'b0;
  logic        reset, instr_valid, instr_ready, reg_write, reg_set, reg_set_upper;
  logic        PC_select, mem_read, mem_write, mem_req, mem_we, mem_ack;
  logic [15:0] instruction, alu_a, alu_b, alu_result, address, write_data, read_data, PC;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] sbExp [$];
  string       sbName [$];
  logic [15:0] obsQ [$];

  datapath_mc #(.WIDTH(16), .PC_STEP(2), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .reg_write(reg_write), .reg_set(reg_set), .reg_set_upper(reg_set_upper),
    .PC_select(PC_select), .mem_read(mem_read), .mem_write(mem_write),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .address(address), .write_data(write_data), .read_data(read_data), .PC(PC)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expectVal(input string n, input logic [15:0] v);
    sbName.push_back(n);
    sbExp.push_back(v);
  endtask

  task automatic observe(input logic [15:0] v);
    obsQ.push_back(v);
  endtask

  task automatic clearControls();
    instr_valid   = 1'b0;
    reg_write     = 1'b0;
    reg_set       = 1'b0;
    reg_set_upper = 1'b0;
    PC_select     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
  endtask

  task automatic issue(input logic [3:0] x, y, z, input logic set, upper, wr,
                       input logic jmp, mrd, mwr, input logic [15:0] alu);
    instruction   = {4'h0, x, y, z};
    reg_set       = set;
    reg_set_upper = upper;
    reg_write     = wr;
    PC_select     = jmp;
    mem_read      = mrd;
    mem_write     = mwr;
    alu_result    = alu;
    instr_valid   = 1'b1;
    tick();
    clearControls();
  endtask

  task automatic readReg(input logic [3:0] r, output logic [15:0] v);
    instruction = {4'h0, r, 8'h00};
    #1;
    v = alu_a;
  endtask

  // Drains the scoreboard against what the scenario observed
  task automatic drain();
    logic [15:0] e, o;
    string n;
    while (sbExp.size() > 0) begin
      e = sbExp.pop_front();
      n = sbName.pop_front();
      o = (obsQ.size() > 0) ? obsQ.pop_front() : 16'hxxxx;
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    expectVal("reset_pc", 16'h0000);    observe(PC);
    expectVal("reset_ready", 16'h0001); observe({15'b0, instr_ready});
    expectVal("reset_memreq", 16'h0000); observe({15'b0, mem_req});
    readReg(4'd3, v);
    expectVal("reset_r3", 16'h0000);    observe(v);
    drain();
  endtask

  task automatic test_set_jump();
    logic [15:0] v;
    issue(4'hA, 4'h5, 4'd3, 1, 0, 0, 0, 0, 0, 16'h0);
    readReg(4'd3, v);
    expectVal("set_r3", 16'h00A5);  observe(v);
    expectVal("set_pc", 16'h0002);  observe(PC);
    issue(4'd3, 4'h0, 4'd0, 0, 0, 0, 1, 0, 0, 16'h0);
    expectVal("jump_pc", 16'h00A5); observe(PC);
    drain();
  endtask

  task automatic test_upper();
    logic [15:0] v;
    issue(4'h1, 4'h2, 4'd3, 1, 1, 0, 0, 0, 0, 16'h0);
    readReg(4'd3, v);
    expectVal("upper_r3", 16'h12A5); observe(v);
    expectVal("upper_pc", 16'h00A7); observe(PC);
    drain();
  endtask

  task automatic test_load();
    logic [15:0] v;
    issue(4'h4, 4'h0, 4'd1, 1, 0, 0, 0, 0, 0, 16'h0);
    mem_ack = 1'b1; read_data = 16'h0001;
    tick();
    mem_ack = 1'b0;
    expectVal("ack_in_run_pc", 16'h00A9);  observe(PC);
    expectVal("ack_in_run_req", 16'h0000); observe({15'b0, mem_req});
    issue(4'd1, 4'h0, 4'd2, 0, 0, 0, 0, 1, 0, 16'h0);
    // Junk instruction held valid during MEM must be ignored
    instruction = {4'h0, 4'h7, 4'h7, 4'd2}; reg_set = 1'b1; instr_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      expectVal("load_req", 16'h0001);   observe({15'b0, mem_req});
      expectVal("load_addr", 16'h0040);  observe(address);
      expectVal("load_ready", 16'h0000); observe({15'b0, instr_ready});
      expectVal("load_we", 16'h0000);    observe({15'b0, mem_we});
      expectVal("load_pc_hold", 16'h00A9); observe(PC);
      if (c == 2) begin mem_ack = 1'b1; read_data = 16'hBEEF; end
      tick();
    end
    clearControls();
    mem_ack = 1'b0;
    expectVal("load_req_done", 16'h0000);  observe({15'b0, mem_req});
    expectVal("load_ready_done", 16'h0001); observe({15'b0, instr_ready});
    expectVal("load_pc", 16'h00AB);        observe(PC);
    readReg(4'd2, v);
    expectVal("load_r2", 16'hBEEF);        observe(v);
    drain();
  endtask

  task automatic test_r0_store();
    logic [15:0] v;
    issue(4'hF, 4'hF, 4'd0, 1, 0, 0, 0, 0, 0, 16'h0);
    readReg(4'd0, v);
    expectVal("r0_zero", 16'h0000); observe(v);
    expectVal("r0_pc", 16'h00AD);   observe(PC);
    issue(4'd1, 4'd2, 4'd2, 0, 0, 0, 0, 1, 1, 16'h0);
    expectVal("store_we", 16'h0001);    observe({15'b0, mem_we});
    expectVal("store_data", 16'hBEEF);  observe(write_data);
    expectVal("store_addr", 16'h0040);  observe(address);
    mem_ack = 1'b1; read_data = 16'h5555;
    tick();
    mem_ack = 1'b0;
    readReg(4'd2, v);
    expectVal("store_r2_kept", 16'hBEEF); observe(v);
    expectVal("store_pc", 16'h00AF);      observe(PC);
    expectVal("run_we_zero", 16'h0000);   observe({15'b0, mem_we});
    expectVal("run_wdata_zero", 16'h0000); observe(write_data);
    expectVal("run_addr_zero", 16'h0000); observe(address);
    drain();
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    issue(4'hF, 4'hE, 4'd4, 1, 0, 0, 0, 0, 0, 16'h0);
    issue(4'hF, 4'hF, 4'd4, 1, 1, 0, 0, 0, 0, 16'h0);
    issue(4'd4, 4'h0, 4'd0, 0, 0, 0, 1, 0, 0, 16'h0);
    expectVal("wrap_jump_pc", 16'hFFFE); observe(PC);
    instruction = {4'h0, 4'd5, 4'd0, 4'd5}; reg_write = 1'b1;
    alu_result = 16'h1234; instr_valid = 1'b1;
    #1;
    expectVal("no_bypass", 16'h0000); observe(alu_a);
    tick();
    clearControls();
    expectVal("wrap_pc", 16'h0000); observe(PC);
    readReg(4'd5, v);
    expectVal("alu_r5", 16'h1234);  observe(v);
    drain();
  endtask

  task automatic test_reset_in_mem();
    logic [15:0] v;
    issue(4'h0, 4'h0, 4'd0, 0, 0, 0, 0, 0, 0, 16'h0);
    expectVal("pre_pc", 16'h0002); observe(PC);
    issue(4'd1, 4'h0, 4'd2, 0, 0, 0, 0, 1, 0, 16'h0);
    expectVal("rst_mem_req", 16'h0001); observe({15'b0, mem_req});
    reset = 1'b1; mem_ack = 1'b1; read_data = 16'h1111;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    expectVal("rst_pc", 16'h0000);     observe(PC);
    expectVal("rst_req", 16'h0000);    observe({15'b0, mem_req});
    expectVal("rst_ready", 16'h0001);  observe({15'b0, instr_ready});
    readReg(4'd2, v);
    expectVal("rst_r2", 16'h0000);     observe(v);
    readReg(4'd1, v);
    expectVal("rst_r1", 16'h0000);     observe(v);
    mem_ack = 1'b1; read_data = 16'h2222;
    tick();
    mem_ack = 1'b0;
    expectVal("late_ack_pc", 16'h0000); observe(PC);
    readReg(4'd2, v);
    expectVal("late_ack_r2", 16'h0000); observe(v);
    drain();
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; read_data = '0; alu_result = '0;
    instruction = '0;
    clearControls();
    test_reset();
    test_set_jump();
    test_upper();
    test_load();
    test_r0_store();
    test_wrap();
    test_reset_in_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16; data, register, address and PC width; legal values 16, 24, 32.
REQ-002 SHALL have parameter PC_STEP, default 2; PC increment per retired instruction.
REQ-003 SHALL have parameter RESET_PC, default 0; PC value after reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL provide the following ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- instruction  in  16  [15:12] opcode (unused here), [11:8] x, [7:4] y, [3:0] z.
- instr_valid  in  1  instruction and controls are valid.
- instr_ready  out  1  datapath can accept an instruction.
- reg_write  in  1  write alu_result to register z.
- reg_set  in  1  write the immediate {x,y} to register z.
- reg_set_upper  in  1  with reg_set, write the immediate to bits [15:8] instead of [7:0].
- PC_select  in  1  jump: PC takes register x.
- mem_read  in  1  load: register z <= memory[reg x].
- mem_write  in  1  store: memory[reg x] <= reg y.
- alu_a  out  WIDTH  register x contents (combinational).
- alu_b  out  WIDTH  register y contents (combinational).
- alu_result  in  WIDTH  external ALU result.
- mem_req  out  1  memory request active.
- mem_we  out  1  request is a write.
- mem_ack  in  1  memory completes the request this cycle.
- address  out  WIDTH  memory address.
- write_data  out  WIDTH  store data.
- read_data  in  WIDTH  load data, valid with mem_ack.
- PC  out  WIDTH  program counter.

Function
REQ-006 SHALL contain 16 registers of WIDTH bits; r0 reads as 0 and writes to r0 are discarded.
REQ-007 SHALL have FSM states RUN and MEM; instr_ready = 1 only in RUN.
REQ-008 SHALL accept an instruction on any edge where instr_valid & instr_ready; controls are sampled only then.
REQ-009 SHALL, for an accepted non-memory instruction, complete the register write and PC update at the accepting edge (1-cycle latency); state stays RUN.
REQ-010 SHALL apply register-write priority: reg_set, then reg_write; neither asserted means no write.
REQ-011 SHALL, for reg_set with reg_set_upper=0, write z <= zero-extended {x,y}.
REQ-012 SHALL, for reg_set with reg_set_upper=1, write z[15:8] <= {x,y} and leave all other bits unchanged.
REQ-013 SHALL update PC <= register x when PC_select=1, else PC <= PC + PC_STEP; arithmetic is modulo 2^WIDTH.
REQ-014 SHALL, for an accepted mem_read or mem_write, perform no register write and no PC change at that edge.
REQ-015 SHALL, for an accepted memory instruction, latch reg x to address, reg y to write_data, z, and the direction, then enter MEM.
REQ-016 SHALL, when mem_read and mem_write are both 1, treat the instruction as a store.
REQ-017 SHALL hold mem_req=1 in MEM with mem_we, address and write_data stable until ack.
REQ-018 SHALL, on an edge in MEM with mem_ack=1:
- load: write z <= read_data, subject to REQ-006.
- PC <= PC + PC_STEP.
- return to RUN; mem_req deasserts in the following cycle.
REQ-019 SHALL ignore mem_ack in RUN, and ignore instr_valid and all controls in MEM.
REQ-020 SHALL provide no bypass: alu_a and alu_b show register contents before the current edge's write.
REQ-021 SHALL drive mem_we, address and write_data to 0 while in RUN.

Reset
REQ-022 SHALL, on an edge with reset=1, set PC=RESET_PC, all registers to 0 and state to RUN.
REQ-023 SHALL take effect as follows: mem_req=0 and instr_ready=1 from the cycle after the reset edge.
REQ-024 SHALL let reset during MEM abandon the pending transaction: no register write, no PC change; a later mem_ack is ignored.
REQ-025 SHALL give reset priority over every simultaneous event, including acceptance and mem_ack.

Verification
REQ-026 SHALL cover set/jump: reset, accept reg_set x=4'hA y=4'h5 z=3, then PC_select x=3 -> r3=16'h00A5, PC=2, then PC=16'h00A5.
REQ-027 SHALL cover upper set: r3=16'h00A5, reg_set_upper x=4'h1 y=4'h2 z=3 -> r3=16'h12A5.
REQ-028 SHALL cover load with wait: r1=16'h0040, mem_read x=1 z=2, mem_ack after 3 cycles with read_data=16'hBEEF:
- mem_req high 3 cycles, address=16'h0040.
- instr_ready low throughout.
- r2=16'hBEEF and PC+=2 at ack.
REQ-029 SHALL cover r0 and store: reg_set z=0 -> r0 reads 0; mem_write x=1 y=2 -> mem_we=1, write_data=r2.
REQ-030 SHALL cover wrap and reset: PC=16'hFFFE plus one ALU instruction -> PC=0; reset asserted in MEM with mem_ack the same cycle -> PC=RESET_PC, load register unchanged.
